// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters, registered sync/blank
// decode, and a per-frame strobe with a wrapping frame counter.
module vga_controller #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_START = 144,
    parameter int unsigned H_END   = 784,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_START = 35,
    parameter int unsigned V_END   = 515
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixelEn,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       Bright,
    output logic       frameTick,
    output logic [7:0] frameCount
);

    localparam int unsigned DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_q;
    logic          div_last;
    logic [9:0]    h_d;
    logic [9:0]    v_d;
    logic          frame_wrap;

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        h_d        = hCount;
        v_d        = vCount;
        frame_wrap = 1'b0;
        if (div_last) begin
            if (hCount == 10'(H_TOTAL - 1)) begin
                h_d = 10'd0;
                if (vCount == 10'(V_TOTAL - 1)) begin
                    v_d        = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = vCount + 10'd1;
                end
            end else begin
                h_d = hCount + 10'd1;
            end
        end
    end

    // Decode from the next-state counts so sync/blank switch on the same edge as the counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q      <= '0;
            pixelEn    <= 1'b0;
            hCount     <= 10'd0;
            vCount     <= 10'd0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            Bright     <= 1'b0;
            frameTick  <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            div_q      <= div_last ? '0 : div_q + 1'b1;
            pixelEn    <= div_last;
            hCount     <= h_d;
            vCount     <= v_d;
            hSync      <= (h_d >= 10'(H_SYNC));
            vSync      <= (v_d >= 10'(V_SYNC));
            Bright     <= (h_d >= 10'(H_START)) && (h_d < 10'(H_END)) &&
                          (v_d >= 10'(V_START)) && (v_d < 10'(V_END));
            frameTick  <= frame_wrap;
            frameCount <= frameCount + {7'd0, frame_wrap};
        end
    end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: a full-size instance for line-level timing and a shrunken instance
// for frame-level behaviour, both checked every cycle against an arithmetic position model.
module tb_vga_controller;

    localparam int S_DIV = 2;
    localparam int S_HT  = 12;
    localparam int S_HS  = 2;
    localparam int S_HST = 3;
    localparam int S_HE  = 10;
    localparam int S_VT  = 6;
    localparam int S_VS  = 1;
    localparam int S_VST = 2;
    localparam int S_VE  = 5;
    localparam int S_FRAME = S_DIV * S_HT * S_VT;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst_d, rst_s;
    logic       d_pe, d_hs, d_vs, d_br, d_tick;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       s_pe, s_hs, s_vs, s_br, s_tick;
    logic [9:0] s_h, s_v;
    logic [7:0] s_fc;

    vga_controller u_dflt (
        .Clk(Clk), .Reset(rst_d), .pixelEn(d_pe), .hCount(d_h), .vCount(d_v),
        .hSync(d_hs), .vSync(d_vs), .Bright(d_br), .frameTick(d_tick), .frameCount(d_fc)
    );

    vga_controller #(
        .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_START(S_HST), .H_END(S_HE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_START(S_VST), .V_END(S_VE)
    ) u_small (
        .Clk(Clk), .Reset(rst_s), .pixelEn(s_pe), .hCount(s_h), .vCount(s_v),
        .hSync(s_hs), .vSync(s_vs), .Bright(s_br), .frameTick(s_tick), .frameCount(s_fc)
    );

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;
    longint t_d = 0;
    longint t_s = 0;

    // Non-reset edges since the last reset; the model derives everything from this count.
    always @(posedge Clk) begin
        t_d <= rst_d ? 0 : t_d + 1;
        t_s <= rst_s ? 0 : t_s + 1;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {pixelEn, hCount, vCount, hSync, vSync, Bright, frameTick, frameCount}
    function automatic logic [32:0] model(input longint t, input int dv, input int ht,
                                          input int hs, input int hst, input int he,
                                          input int vt, input int vs, input int vst,
                                          input int ve);
        longint p, h, line, v, f;
        logic pe;
        p    = t / dv;
        h    = p % ht;
        line = p / ht;
        v    = line % vt;
        f    = (line / vt) % 256;
        pe   = (t > 0) && (t % dv == 0);
        return {pe, 10'(h), 10'(v), (h >= hs), (v >= vs),
                (h >= hst && h < he && v >= vst && v < ve), (pe && h == 0 && v == 0), 8'(f)};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            check("dflt_cycle", {d_pe, d_h, d_v, d_hs, d_vs, d_br, d_tick, d_fc},
                  model(t_d, 4, 800, 96, 144, 784, 525, 2, 35, 515));
            check("small_cycle", {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_tick, s_fc},
                  model(t_s, S_DIV, S_HT, S_HS, S_HST, S_HE, S_VT, S_VS, S_VST, S_VE));
        end
    end

    initial begin
        int first_pe, first_h, hs_low, hs_high, s_first_tick, s_bright, s_vs_low, guard;
        rst_d = 1'b1;
        rst_s = 1'b1;
        @(negedge Clk);
        chk_en = 1'b1;
        repeat (9) @(negedge Clk);
        check("reset_state", {d_pe, d_h, d_v, d_hs, d_vs, d_br, d_tick, d_fc}, 33'd0);

        rst_d = 1'b0;
        rst_s = 1'b0;
        first_pe = -1; first_h = 0; hs_low = 0; hs_high = 0;
        s_first_tick = -1; s_bright = 0; s_vs_low = 0;
        for (int i = 0; i < 3200; i++) begin
            if (d_pe && first_pe < 0) begin
                first_pe = i;
                first_h  = int'(d_h);
            end
            if (d_hs) hs_high++;
            else hs_low++;
            if (i <= S_FRAME) begin
                if (s_tick && s_first_tick < 0) s_first_tick = i;
                if (s_pe && s_br) s_bright++;
            end
            if (i < S_FRAME && !s_vs) s_vs_low++;
            @(negedge Clk);
        end
        check("first_pixel_en", 33'(first_pe), 33'd4);
        check("first_hcount", 33'(first_h), 33'd1);
        check("hsync_low", 33'(hs_low), 33'd384);
        check("hsync_high", 33'(hs_high), 33'd2816);
        check("small_frame_period", 33'(s_first_tick), 33'd144);
        check("small_bright_pixels", 33'(s_bright), 33'd21);
        check("small_vsync_low", 33'(s_vs_low), 33'd24);

        // Mid-line reset on the full-size instance.
        guard = 0;
        while (d_h != 10'd400 && guard < 4000) begin
            @(negedge Clk);
            guard++;
        end
        check("reach_h400", 33'(d_h), 33'd400);
        rst_d = 1'b1;
        @(negedge Clk);
        check("midline_reset", {d_pe, d_h, d_v, d_hs, d_vs, d_br, d_tick, d_fc}, 33'd0);
        repeat (2) @(negedge Clk);
        rst_d = 1'b0;

        // Random reset pulses on the small instance, checked cycle by cycle by the model.
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(400, 1)) @(negedge Clk);
            rst_s = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge Clk);
            rst_s = 1'b0;
        end

        repeat (255 * S_FRAME) @(negedge Clk);
        check("fc_255", {25'd0, s_fc}, 33'd255);
        check("tick_255", {32'd0, s_tick}, 33'd1);
        @(negedge Clk);
        check("tick_single", {32'd0, s_tick}, 33'd0);
        repeat (S_FRAME - 1) @(negedge Clk);
        check("fc_wrap", {25'd0, s_fc}, 33'd0);
        check("hv_wrap", {23'd0, s_h, s_v}, 33'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
